// File: rtl/nbbpu_pkg.sv
// Shared definitions for the NBBPU core: data widths, opcode map,
// controller state encoding and next-PC source select.
package nbbpu_pkg;

    localparam int WORD_WIDTH     = 16;
    localparam int REG_ADDR_WIDTH = 4;

    // Opcode map, IR[15:12]
    localparam logic [3:0] OP_ADD      = 4'h0;
    localparam logic [3:0] OP_SUB      = 4'h1;
    localparam logic [3:0] OP_AND      = 4'h2;
    localparam logic [3:0] OP_OR       = 4'h3;
    localparam logic [3:0] OP_XOR      = 4'h4;
    localparam logic [3:0] OP_NOT      = 4'h5;
    localparam logic [3:0] OP_SHL      = 4'h6;
    localparam logic [3:0] OP_SHR      = 4'h7;
    localparam logic [3:0] OP_JUMP     = 4'h8;
    localparam logic [3:0] OP_BEQ      = 4'h9;
    localparam logic [3:0] OP_BNE      = 4'hA;
    localparam logic [3:0] OP_RESERVED = 4'hB;
    localparam logic [3:0] OP_LOAD     = 4'hC;
    localparam logic [3:0] OP_STORE    = 4'hD;
    localparam logic [3:0] OP_SETLO    = 4'hE;
    localparam logic [3:0] OP_SETHI    = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEMORY  = 3'd3,
        S_HALT    = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        PC_HOLD  = 2'd0,
        PC_INC   = 2'd1,
        PC_X     = 2'd2,
        PC_RESET = 2'd3
    } pc_sel_t;

endpackage

// File: rtl/pc_next.sv
// Next program-counter select: hold, increment (wrapping), jump target X,
// or the reset vector.
module pc_next
    import nbbpu_pkg::*;
#(
    parameter logic [WORD_WIDTH-1:0] RESET_PC = '0
) (
    input  pc_sel_t               sel,
    input  logic [WORD_WIDTH-1:0] pc,
    input  logic [WORD_WIDTH-1:0] x,
    output logic [WORD_WIDTH-1:0] pc_d
);

    // Pick the source for the next PC value
    always_comb begin
        pc_d = pc;
        case (sel)
            PC_HOLD:  pc_d = pc;
            PC_INC:   pc_d = pc + WORD_WIDTH'(1);
            PC_X:     pc_d = x;
            PC_RESET: pc_d = RESET_PC;
            default:  pc_d = pc;
        endcase
    end

endmodule

// File: rtl/controller.sv
// NBBPU multi-cycle sequencer: fetch, decode, execute and the data-memory
// handshake for load/store. Drives the ALU instruction/PC inputs.
// Optional build macro CONTROLLER_HALT_ON_RESERVED_EN: opcode 1011 parks the
// core in HALT until reset; without it 1011 behaves as a NOP.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_FETCH   | instruction_request high, waiting for instruction_valid
// S_DECODE  | one cycle for register-file read and ALU settling
// S_EXECUTE | commit ALU/jump/branch result or move on to MEMORY
// S_MEMORY  | data_request high, waiting for data_ready
// S_HALT    | core stopped, left only through reset
module controller
    import nbbpu_pkg::*;
#(
    parameter logic [WORD_WIDTH-1:0] RESET_PC = 16'h0000
) (
    input  logic                      clock,
    input  logic                      reset,
    output logic                      instruction_request,
    input  logic                      instruction_valid,
    input  logic [WORD_WIDTH-1:0]     instruction_data,
    output logic [WORD_WIDTH-1:0]     PC,
    output logic [WORD_WIDTH-1:0]     instruction,
    output logic [REG_ADDR_WIDTH-1:0] x_address,
    output logic [REG_ADDR_WIDTH-1:0] y_address,
    output logic [REG_ADDR_WIDTH-1:0] z_address,
    input  logic [WORD_WIDTH-1:0]     X,
    input  logic [WORD_WIDTH-1:0]     Z,
    output logic                      reg_write,
    output logic                      data_request,
    output logic                      data_write,
    output logic [WORD_WIDTH-1:0]     data_address,
    input  logic                      data_ready,
    output logic                      halted
);

    state_t                state_q;
    state_t                state_d;
    logic [WORD_WIDTH-1:0] pc_q;
    logic [WORD_WIDTH-1:0] pc_d;
    logic [WORD_WIDTH-1:0] ir_q;
    logic                  ir_load;
    pc_sel_t               pc_sel;
    logic [3:0]            opcode;
    logic                  unused_z_upper;

    assign opcode         = ir_q[15:12];
    assign unused_z_upper = ^Z[WORD_WIDTH-1:1];

    pc_next #(
        .RESET_PC (RESET_PC)
    ) u_pc_next (
        .sel  (pc_sel),
        .pc   (pc_q),
        .x    (X),
        .pc_d (pc_d)
    );

    // State, PC and IR registers; reset is synchronous and also steers the
    // PC mux to the reset vector
    always_ff @(posedge clock) begin
        pc_q <= pc_d;
        if (!reset) begin
            state_q <= S_FETCH;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            if (ir_load) begin
                ir_q <= instruction_data;
            end
        end
    end

    // Next-state, PC source and strobe decode
    always_comb begin
        state_d             = state_q;
        pc_sel              = PC_HOLD;
        ir_load             = 1'b0;
        instruction_request = 1'b0;
        reg_write           = 1'b0;
        data_request        = 1'b0;
        data_write          = 1'b0;
        halted              = 1'b0;

        case (state_q)
            S_FETCH: begin
                instruction_request = 1'b1;
                if (instruction_valid) begin
                    ir_load = 1'b1;
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                state_d = S_EXECUTE;
            end

            S_EXECUTE: begin
                state_d = S_FETCH;
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT,
                    OP_SHL, OP_SHR, OP_SETLO, OP_SETHI: begin
                        reg_write = 1'b1;
                        pc_sel    = PC_INC;
                    end
                    OP_JUMP: begin
                        // ALU presents the link value PC+1 on Z
                        reg_write = 1'b1;
                        pc_sel    = PC_X;
                    end
                    OP_BEQ, OP_BNE: begin
                        // ALU resolves the condition into Z[0]
                        pc_sel = Z[0] ? PC_X : PC_INC;
                    end
                    OP_LOAD, OP_STORE: begin
                        state_d = S_MEMORY;
                    end
                    OP_RESERVED: begin
`ifdef CONTROLLER_HALT_ON_RESERVED_EN
                        state_d = S_HALT;
`else
                        pc_sel  = PC_INC;
`endif
                    end
                    default: begin
                        pc_sel = PC_INC;
                    end
                endcase
            end

            S_MEMORY: begin
                data_request = 1'b1;
                data_write   = (opcode == OP_STORE);
                if (data_ready) begin
                    reg_write = (opcode == OP_LOAD);
                    pc_sel    = PC_INC;
                    state_d   = S_FETCH;
                end
            end

            S_HALT: begin
`ifdef CONTROLLER_HALT_ON_RESERVED_EN
                halted = 1'b1;
`else
                state_d = S_FETCH;
`endif
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase

        if (!reset) begin
            pc_sel = PC_RESET;
        end
    end

    assign PC           = pc_q;
    assign instruction  = ir_q;
    assign x_address    = ir_q[11:8];
    assign y_address    = ir_q[7:4];
    assign z_address    = ir_q[3:0];
    assign data_address = data_request ? X : '0;

endmodule

// File: tb/tb_controller.sv
// Scoreboard bench for the NBBPU controller. Stimulus pushes the expected
// fetch / memory / writeback events; a negedge monitor pops and compares them.
module tb_controller;
    import nbbpu_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        instruction_request;
    logic        instruction_valid = 1'b0;
    logic [15:0] instruction_data  = 16'h0000;
    logic [15:0] PC;
    logic [15:0] instruction;
    logic [3:0]  x_address, y_address, z_address;
    logic [15:0] X = 16'h0000;
    logic [15:0] Z = 16'h0000;
    logic        reg_write;
    logic        data_request;
    logic        data_write;
    logic [15:0] data_address;
    logic        data_ready = 1'b0;
    logic        halted;

    always #5 clock = ~clock;

    controller #(.RESET_PC(16'h0010)) dut (
        .clock               (clock),
        .reset               (reset),
        .instruction_request (instruction_request),
        .instruction_valid   (instruction_valid),
        .instruction_data    (instruction_data),
        .PC                  (PC),
        .instruction         (instruction),
        .x_address           (x_address),
        .y_address           (y_address),
        .z_address           (z_address),
        .X                   (X),
        .Z                   (Z),
        .reg_write           (reg_write),
        .data_request        (data_request),
        .data_write          (data_write),
        .data_address        (data_address),
        .data_ready          (data_ready),
        .halted              (halted)
    );

    localparam logic [1:0] EV_FETCH = 2'd0;
    localparam logic [1:0] EV_MEM   = 2'd1;
    localparam logic [1:0] EV_WRITE = 2'd2;

    typedef struct {
        logic [1:0]  kind;
        logic [15:0] val;
        logic        flag;
    } ev_t;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] x;
        logic [15:0] z;
        int          stall;
        int          md;
        logic [15:0] nxt;
        int          lat;
        bit          wr;
        bit          mem;
        bit          dw;
    } vec_t;

    ev_t         sb[$];
    vec_t        vecs[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_ev(input logic [1:0] k, input logic [15:0] v, input logic f);
        ev_t e;
        e.kind = k;
        e.val  = v;
        e.flag = f;
        sb.push_back(e);
    endtask

    task automatic observe(input logic [1:0] k, input logic [15:0] v, input logic f);
        ev_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_event: got kind %0d val %h, expected no event", k, v);
        end else begin
            e = sb.pop_front();
            check("event_kind", 32'(k), 32'(e.kind));
            check("event_val",  32'(v), 32'(e.val));
            check("event_flag", 32'(f), 32'(e.flag));
        end
    endtask

    task automatic add(input logic [15:0] instr, input logic [15:0] x, input logic [15:0] z,
                       input int stall, input int md, input logic [15:0] nxt, input int lat,
                       input bit wr, input bit mem, input bit dw);
        vec_t v;
        v.instr = instr; v.x = x; v.z = z; v.stall = stall; v.md = md;
        v.nxt = nxt; v.lat = lat; v.wr = wr; v.mem = mem; v.dw = dw;
        vecs.push_back(v);
    endtask

    task automatic wait_request(input string name);
        int guard = 0;
        while (!instruction_request && guard < 20) begin
            @(posedge clock); #1;
            guard++;
        end
        if (!instruction_request) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got no instruction_request, expected one within 20 cycles", name);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int          cnt;
        int          dcnt;
        logic [15:0] pc0;
        logic [15:0] ir0;
        wait_request("fetch");
        X = v.x;
        Z = v.z;
        push_ev(EV_FETCH, exp_pc, 1'b0);
        if (v.mem) push_ev(EV_MEM, v.x, v.dw);
        if (v.wr)  push_ev(EV_WRITE, {12'h000, v.instr[3:0]}, 1'b0);
        pc0 = PC;
        ir0 = instruction;
        instruction_data = 16'hDEAD;
        repeat (v.stall) begin
            @(posedge clock); #1;
        end
        if (v.stall > 0) begin
            check("stall_pc",  32'(PC), 32'(pc0));
            check("stall_ir",  32'(instruction), 32'(ir0));
            check("stall_req", 32'(instruction_request), 32'd1);
        end
        instruction_valid = 1'b1;
        instruction_data  = v.instr;
        @(posedge clock); #1;
        instruction_valid = 1'b0;
        instruction_data  = 16'hDEAD;
        check("ir_latch", 32'(instruction), 32'(v.instr));
        cnt  = 1;
        dcnt = 0;
        while (!instruction_request && cnt < 40) begin
            // stray valid/ready outside their states must be ignored
            instruction_valid = 1'b1;
            if (data_request) begin
                data_ready = (dcnt == v.md);
                dcnt++;
            end else begin
                data_ready = 1'b1;
            end
            @(posedge clock); #1;
            instruction_valid = 1'b0;
            data_ready        = 1'b0;
            cnt++;
        end
        check("latency", 32'(cnt), 32'(v.lat));
        if (v.mem) check("dreq_cycles", 32'(dcnt), 32'(v.md + 1));
        check("next_pc", 32'(PC), 32'(v.nxt));
        exp_pc = v.nxt;
    endtask

    // Monitor: turn DUT handshakes into events and match them against the queue
    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                if (instruction_request && instruction_valid) observe(EV_FETCH, PC, 1'b0);
                if (data_request && data_ready)               observe(EV_MEM, data_address, data_write);
                if (reg_write)                                observe(EV_WRITE, {12'h000, z_address}, 1'b0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] pc0;
        int          guard;

        //     instr     x         z         st md nxt       lat wr mem dw
        add(16'h0123, 16'h0000, 16'h0000, 0, 0, 16'h0011, 3, 1, 0, 0);
        add(16'h1456, 16'h0000, 16'h0000, 5, 0, 16'h0012, 3, 1, 0, 0);
        add(16'h9120, 16'h0040, 16'h0001, 0, 0, 16'h0040, 3, 0, 0, 0);
        add(16'h9120, 16'h0040, 16'h0000, 0, 0, 16'h0041, 3, 0, 0, 0);
        add(16'hA120, 16'h0300, 16'hFFFE, 0, 0, 16'h0042, 3, 0, 0, 0);
        add(16'h8105, 16'h0200, 16'h0000, 0, 0, 16'h0200, 3, 1, 0, 0);
        add(16'hC217, 16'h1234, 16'h0000, 0, 3, 16'h0201, 7, 1, 1, 0);
        add(16'hD218, 16'h4321, 16'h0000, 0, 3, 16'h0202, 7, 0, 1, 1);
        add(16'hC31A, 16'hBEEF, 16'h0000, 0, 0, 16'h0203, 4, 1, 1, 0);
        add(16'h8100, 16'hFFFF, 16'h0000, 0, 0, 16'hFFFF, 3, 1, 0, 0);
        add(16'h7ABC, 16'h0000, 16'h0000, 0, 0, 16'h0000, 3, 1, 0, 0);
`ifndef CONTROLLER_HALT_ON_RESERVED_EN
        add(16'hB000, 16'h0000, 16'h0000, 0, 0, 16'h0001, 3, 0, 0, 0);
`endif

        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_pc",    32'(PC), 32'h0010);
        check("rst_ir",    32'(instruction), 32'h0000);
        check("rst_req",   32'(instruction_request), 32'd1);
        check("rst_strb",  32'({reg_write, data_request, halted}), 32'd0);
        reset  = 1'b1;
        exp_pc = 16'h0010;

        foreach (vecs[i]) run_vec(vecs[i]);

        // reset while a load is waiting on memory
        wait_request("midmem_fetch");
        X = 16'h5555;
        push_ev(EV_FETCH, exp_pc, 1'b0);
        instruction_valid = 1'b1;
        instruction_data  = 16'hC111;
        @(posedge clock); #1;
        instruction_valid = 1'b0;
        guard = 0;
        while (!data_request && guard < 10) begin
            @(posedge clock); #1;
            guard++;
        end
        repeat (2) @(posedge clock);
        #1;
        check("midmem_dreq", 32'(data_request), 32'd1);
        reset = 1'b0;
        @(posedge clock); #1;
        check("midrst_dreq", 32'(data_request), 32'd0);
        check("midrst_pc",   32'(PC), 32'h0010);
        check("midrst_req",  32'(instruction_request), 32'd1);
        check("midrst_ir",   32'(instruction), 32'h0000);
        reset  = 1'b1;
        exp_pc = 16'h0010;
        begin
            vec_t v;
            v.instr = 16'h0001; v.x = 16'h0000; v.z = 16'h0000; v.stall = 0; v.md = 0;
            v.nxt = 16'h0011; v.lat = 3; v.wr = 1'b1; v.mem = 1'b0; v.dw = 1'b0;
            run_vec(v);
        end

`ifdef CONTROLLER_HALT_ON_RESERVED_EN
        wait_request("halt_fetch");
        push_ev(EV_FETCH, exp_pc, 1'b0);
        instruction_valid = 1'b1;
        instruction_data  = 16'hB000;
        @(posedge clock); #1;
        instruction_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        for (int i = 0; i < 10; i++) begin
            check("halt_flag",  32'(halted), 32'd1);
            check("halt_strb",  32'({instruction_request, reg_write, data_request}), 32'd0);
            check("halt_pc",    32'(PC), 32'(exp_pc));
            @(posedge clock); #1;
        end
        reset = 1'b0;
        @(posedge clock); #1;
        check("halt_rst", 32'(halted), 32'd0);
        reset = 1'b1;
`endif

        repeat (3) @(posedge clock);
        #1;
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
